// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises multi-byte packets from NUM_REQ sources onto one UART transmitter.
// Optional tx_busy watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter logic [17:0] BYTE_GAP = 18'hfff,
  parameter logic [17:0] PACK_GAP = 18'h3ffff,
  parameter logic [17:0] TIMEOUT  = 18'h3ffff
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_len,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   arb_busy,
  output logic                   tx_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $bits(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [NUM_REQ-1:0] ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;

  logic [2:0]       state_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [1:0]       byte_idx_r;
  logic [1:0]       len_r;
  logic [31:0]      data_r;
  logic [CNT_W-1:0] gap_r;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wd_r;
`endif

  logic             found_s;
  logic [IDX_W-1:0] win_s;
  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] nxt_ptr_s;

  // Round-robin scan of req starting at rr_ptr; first set bit wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(rr_ptr_r) + i) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    if (win_s == IDX_W'(NUM_REQ - 1)) begin
      nxt_ptr_s = {IDX_W{1'b0}};
    end else begin
      nxt_ptr_s = win_s + IDX_W'(1);
    end
  end

  // Packet sequencer: grant, per-byte start pulse, busy wait, gap timing, completion.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {IDX_W{1'b0}};
      byte_idx_r <= 2'd0;
      len_r      <= 2'd0;
      data_r     <= 32'h0000_0000;
      gap_r      <= {CNT_W{1'b0}};
      grant      <= {NUM_REQ{1'b0}};
      done       <= {NUM_REQ{1'b0}};
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      arb_busy   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_r       <= {CNT_W{1'b0}};
      tx_err     <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant      <= ONE_HOT << win_s;
            data_r     <= req_data[win_s*32 +: 32];
            len_r      <= req_len[win_s*2 +: 2];
            byte_idx_r <= 2'd0;
            rr_ptr_r   <= nxt_ptr_s;
            arb_busy   <= 1'b1;
            state_r    <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          tx_data  <= data_r[{byte_idx_r, 3'b000} +: 8];
          tx_start <= 1'b1;
          state_r  <= SETTLE;
        end
        SETTLE: begin
          // The transmitter raises busy one cycle after start, so don't look at it yet.
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd_r    <= {CNT_W{1'b0}};
`endif
          state_r <= WAIT;
        end
        WAIT: begin
          if (!tx_busy) begin
            gap_r   <= (byte_idx_r != len_r) ? BYTE_GAP : PACK_GAP;
            state_r <= GAP;
          end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (wd_r == TIMEOUT - CNT_ONE) begin
              grant    <= {NUM_REQ{1'b0}};
              done     <= grant;
              tx_err   <= 1'b1;
              arb_busy <= 1'b0;
              state_r  <= IDLE;
            end else begin
              wd_r <= wd_r + CNT_ONE;
            end
`else
            state_r <= WAIT;
`endif
          end
        end
        GAP: begin
          if (gap_r != {CNT_W{1'b0}}) begin
            gap_r <= gap_r - CNT_ONE;
          end else if (byte_idx_r != len_r) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            state_r    <= START;
          end else begin
            grant    <= {NUM_REQ{1'b0}};
            done     <= grant;
            arb_busy <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          grant    <= {NUM_REQ{1'b0}};
          arb_busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_TX_ARB_TIMEOUT_EN
  assign tx_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple busy-timing transmitter model.
module tb_uart_tx_arbiter;

  localparam int          NUM_REQ  = 4;
  localparam logic [17:0] BYTE_GAP = 18'd4;
  localparam logic [17:0] PACK_GAP = 18'd8;
  localparam logic [17:0] TIMEOUT  = 18'd16;
  localparam int          FRAME    = 5;

  logic                  CLK;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  req_len;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_busy;
  logic                  arb_busy;
  logic                  tx_err;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .BYTE_GAP(BYTE_GAP), .PACK_GAP(PACK_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .reset(reset), .req(req), .req_len(req_len), .req_data(req_data),
    .grant(grant), .done(done), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .arb_busy(arb_busy), .tx_err(tx_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int last_fall = 0;
  int grant_cyc = 0;
  logic hold_busy = 1'b0;
  logic prev_busy = 1'b0;
  logic [NUM_REQ-1:0] prev_grant = '0;

  logic [7:0]         byte_q[$];
  int                 sfall_q[$];
  logic [NUM_REQ-1:0] done_q[$];
  logic [NUM_REQ-1:0] grant_q[$];
  int                 gfall_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    byte_q.delete(); sfall_q.delete(); done_q.delete(); grant_q.delete(); gfall_q.delete();
  endtask

  // Advance one cycle: sample on the falling edge, update transmitter model, log events.
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (tx_start) busy_cnt = FRAME;
    else if (busy_cnt != 0) busy_cnt--;
    prev_busy = tx_busy;
    tx_busy = hold_busy | (busy_cnt != 0);
    if (prev_busy && !tx_busy) last_fall = cyc;
    if (tx_start) begin
      byte_q.push_back(tx_data);
      sfall_q.push_back(cyc - last_fall);
    end
    if (done != '0) done_q.push_back(done);
    if (grant != '0 && prev_grant == '0) begin
      grant_q.push_back(grant);
      gfall_q.push_back(cyc - last_fall);
      grant_cyc = cyc;
    end
    prev_grant = grant;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    step();
    while (done == '0 && n < bound) begin
      step();
      n++;
    end
    check(tag, 32'(done != '0), 32'd1);
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp_rr [6];
    int bad;
    int n;
    int g;
    exp_rr = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    reset = 1'b1; req = '0; req_len = '0; req_data = '0; tx_busy = 1'b0;
    repeat (3) step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_arb_busy", 32'(arb_busy), 32'h0);
    check("rst_tx_err", 32'(tx_err), 32'h0);
    reset = 1'b0;
    step();

    // Single two-byte packet from requester 0.
    clear_logs();
    req_len = 8'h01; req_data[31:0] = 32'h0000_A55A; req = 4'b0001;
    step();
    check("t1_grant_lat", 32'(grant), 32'h1);
    req = 4'b0000;
    step();
    check("t1_start_lat", 32'(tx_start), 32'h1);
    check("t1_first_byte", 32'(tx_data), 32'h5A);
    bad = 0; n = 0;
    while (done == '0 && n < 300) begin
      if (grant != 4'b0001) bad++;
      step();
      n++;
    end
    check("t1_grant_hold", 32'(bad), 32'd0);
    check("t1_done", 32'(done), 32'h1);
    check("t1_nbytes", 32'(byte_q.size()), 32'd2);
    check("t1_byte0", 32'(byte_q[0]), 32'h5A);
    check("t1_byte1", 32'(byte_q[1]), 32'hA5);
    check("t1_byte_gap", 32'(sfall_q[1]), 32'(BYTE_GAP) + 32'd3);
    repeat (20) step();
    check("t1_done_once", 32'(done_q.size()), 32'd1);
    check("t1_idle", 32'(arb_busy), 32'h0);

    // Data latched at grant; later changes and dropped req are ignored.
    clear_logs();
    req_len = 8'h03; req_data[31:0] = 32'h4433_2211; req = 4'b0001;
    step();
    check("t2_grant", 32'(grant), 32'h1);
    req_data[31:0] = 32'hFFFF_FFFF; req = 4'b0000;
    wait_done("t2_wait_done", 400);
    check("t2_done", 32'(done), 32'h1);
    check("t2_nbytes", 32'(byte_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_byte%0d", i), 32'(byte_q[i]), 32'(8'h11 * (i + 1)));

    // Round robin from reset with req=1011 held.
    reset = 1'b1; step(); step(); reset = 1'b0;
    clear_logs();
    req_len = 8'h00; req = 4'b1011;
    n = 0;
    while (done_q.size() < 6 && n < 2000) begin
      step();
      n++;
      if (done_q.size() >= 6) req = 4'b0000;
    end
    req = 4'b0000;
    repeat (30) step();
    check("t3_ngrants", 32'(grant_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_grant%0d", i), 32'(grant_q[i]), 32'(exp_rr[i]));
      check($sformatf("t3_done%0d", i), 32'(done_q[i]), 32'(exp_rr[i]));
    end
    // WAIT exit edge + PACK_GAP+1 GAP cycles + IDLE grant edge.
    check("t3_pack_gap", 32'(gfall_q[1]), 32'(PACK_GAP) + 32'd3);

    // Reset in the GAP after byte 0 of a 4-byte packet from requester 1.
    clear_logs();
    req_len = 8'b0000_1100; req_data[63:32] = 32'hDDCC_BBAA; req = 4'b0010;
    step();
    check("t4_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    n = 0;
    while (byte_q.size() < 1 && n < 50) begin step(); n++; end
    n = 0;
    while (tx_busy && n < 50) begin step(); n++; end
    step(); step();
    reset = 1'b1;
    step();
    check("t4_rst_grant", 32'(grant), 32'h0);
    check("t4_rst_done", 32'(done), 32'h0);
    check("t4_rst_tx_start", 32'(tx_start), 32'h0);
    check("t4_rst_tx_data", 32'(tx_data), 32'h0);
    check("t4_rst_arb_busy", 32'(arb_busy), 32'h0);
    reset = 1'b0;
    repeat (20) step();
    check("t4_no_done", 32'(done_q.size()), 32'd0);
    check("t4_one_byte", 32'(byte_q.size()), 32'd1);
    req_len = 8'h00; req = 4'b0100;
    step();
    check("t4_grant2", 32'(grant), 32'h4);
    req = 4'b0000;
    wait_done("t4_wait_done", 200);
    check("t4_done2", 32'(done), 32'h4);

    // Transmitter stuck busy.
    clear_logs();
    repeat (20) step();
    hold_busy = 1'b1; tx_busy = 1'b1; req = 4'b1000;
    step();
    check("t5_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    g = cyc;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wait_done("t5_wait_done", 100);
    check("t5_done", 32'(done), 32'h8);
    check("t5_latency", 32'(cyc - g), 32'(TIMEOUT) + 32'd2);
    check("t5_err", 32'(tx_err), 32'h1);
    repeat (10) step();
    check("t5_err_sticky", 32'(tx_err), 32'h1);
    check("t5_idle", 32'(arb_busy), 32'h0);
    hold_busy = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_err_cleared", 32'(tx_err), 32'h0);
`else
    repeat (100) step();
    check("t5_stuck_busy", 32'(arb_busy), 32'h1);
    check("t5_stuck_grant", 32'(grant), 32'h8);
    check("t5_no_done", 32'(done_q.size()), 32'd0);
    check("t5_err_zero", 32'(tx_err), 32'h0);
    hold_busy = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_recover", 32'(arb_busy), 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
